// File: rtl/axi_pkg.sv
// Shared AXI4 read-side constants and the burst generator state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } rd_state_t;

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry registered valid/ready buffer; both in_ready and the output side come from flops.
module axi_skid_buf #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_hs;

  assign in_hs = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      if (!out_valid || out_ready) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          skid_valid <= 1'b0;
        end else begin
          out_valid <= in_hs;
          if (in_hs) out_data <= in_data;
        end
        in_ready <= 1'b1;
      end else if (in_hs) begin
        // output stalled: park the beat and stop accepting until it drains
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        in_ready   <= 1'b0;
      end else begin
        in_ready <= !skid_valid;
      end
    end
  end

endmodule

// File: rtl/axi_rd_burst_gen.sv
// Splits a (base, byte count) read command into 4 KB-safe AXI4 INCR bursts of 64-bit
// beats and streams the returned data out with a last-beat marker.
//
//   state   | meaning
//   S_IDLE  | waiting for a command, cmd_ready high
//   S_ISSUE | issuing AR bursts until every beat has been requested
//   S_DRAIN | all ARs issued, waiting for the last beat to leave the output
module axi_rd_burst_gen
  import axi_pkg::*;
#(
  parameter int          MAX_BURST = 16,
  parameter int          MAX_OUTST = 4,
  parameter logic [5:0]  ID        = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_bytes,
  output logic        mem_ARVALID,
  input  logic        mem_ARREADY,
  output logic [31:0] mem_ARADDR,
  output logic [7:0]  mem_ARLEN,
  output logic [2:0]  mem_ARSIZE,
  output logic [1:0]  mem_ARBURST,
  output logic [5:0]  mem_ARID,
  output logic        mem_ARLOCK,
  output logic [3:0]  mem_ARCACHE,
  output logic [2:0]  mem_ARPROT,
  output logic [3:0]  mem_ARQOS,
  input  logic        mem_RVALID,
  input  logic [63:0] mem_RDATA,
  input  logic [5:0]  mem_RID,
  input  logic        mem_RLAST,
  input  logic [1:0]  mem_RRESP,
  output logic        mem_RREADY,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        done,
  output logic        err
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  rd_state_t     state;
  logic [31:0]   addr;
  logic [28:0]   beats, beats_left, rcv;
  logic [OW-1:0] outstanding;
  logic          err_flag;
  logic [28:0]   cmd_beats;
  logic [9:0]    bnd, len;
  logic          ar_hs, r_hs, rlast_hs, r_last_flag;
  logic [64:0]   buf_out;
  logic          unused_sigs;

  assign cmd_beats = cmd_bytes[31:3] + 29'(|cmd_bytes[2:0]);

  // bnd = beats left before the next 4 KB page, 1..512
  always_comb begin
    bnd = 10'd512 - {1'b0, addr[11:3]};
    len = 10'(MAX_BURST);
    if (beats_left < 29'(len)) len = beats_left[9:0];
    if (bnd < len) len = bnd;
  end

  assign mem_ARVALID = (state == S_ISSUE) && (outstanding < OW'(MAX_OUTST));
  assign mem_ARADDR  = addr;
  assign mem_ARLEN   = 8'(len - 10'd1);
  assign mem_ARSIZE  = AXI_SIZE_8B;
  assign mem_ARBURST = AXI_BURST_INCR;
  assign mem_ARID    = ID;
  assign mem_ARLOCK  = 1'b0;
  assign mem_ARCACHE = AXI_CACHE_DEF;
  assign mem_ARPROT  = 3'b000;
  assign mem_ARQOS   = 4'b0000;

  assign ar_hs       = mem_ARVALID && mem_ARREADY;
  assign r_hs        = mem_RVALID && mem_RREADY;
  assign rlast_hs    = r_hs && mem_RLAST;
  assign r_last_flag = (rcv == beats - 29'd1);
  assign unused_sigs = ^{cmd_addr[2:0], mem_RID};

  axi_skid_buf #(.W(65)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mem_RVALID),
    .in_ready  (mem_RREADY),
    .in_data   ({r_last_flag, mem_RDATA}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_last = buf_out[64];
  assign out_data = buf_out[63:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      addr        <= '0;
      beats       <= '0;
      beats_left  <= '0;
      rcv         <= '0;
      outstanding <= '0;
      err_flag    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (r_hs) begin
        rcv <= rcv + 29'd1;
        if (mem_RRESP != AXI_RESP_OKAY) err_flag <= 1'b1;
      end
      if (ar_hs && !rlast_hs)      outstanding <= outstanding + OW'(1);
      else if (!ar_hs && rlast_hs) outstanding <= outstanding - OW'(1);
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            addr       <= {cmd_addr[31:3], 3'b000};
            beats      <= cmd_beats;
            beats_left <= cmd_beats;
            rcv        <= '0;
            err_flag   <= 1'b0;
            if (cmd_beats == '0) begin
              done <= 1'b1;
            end else begin
              state     <= S_ISSUE;
              cmd_ready <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          if (ar_hs) begin
            addr       <= addr + {19'd0, len, 3'd0};
            beats_left <= beats_left - 29'(len);
            if (beats_left == 29'(len)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            done      <= 1'b1;
            err       <= err_flag;
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_gen.sv
// Bench for axi_rd_burst_gen: a small AXI read slave returns address-tagged data, and
// expected ARs and output beats are queued when each command is driven.
module tb_axi_rd_burst_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_bytes;
  logic        mem_ARVALID, mem_ARREADY;
  logic [31:0] mem_ARADDR;
  logic [7:0]  mem_ARLEN;
  logic [2:0]  mem_ARSIZE;
  logic [1:0]  mem_ARBURST;
  logic [5:0]  mem_ARID;
  logic        mem_ARLOCK;
  logic [3:0]  mem_ARCACHE;
  logic [2:0]  mem_ARPROT;
  logic [3:0]  mem_ARQOS;
  logic        mem_RVALID;
  logic [63:0] mem_RDATA;
  logic [5:0]  mem_RID;
  logic        mem_RLAST;
  logic [1:0]  mem_RRESP;
  logic        mem_RREADY;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        done, err;

  always #5 clk = ~clk;

  axi_rd_burst_gen dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes),
    .mem_ARVALID(mem_ARVALID), .mem_ARREADY(mem_ARREADY), .mem_ARADDR(mem_ARADDR),
    .mem_ARLEN(mem_ARLEN), .mem_ARSIZE(mem_ARSIZE), .mem_ARBURST(mem_ARBURST),
    .mem_ARID(mem_ARID), .mem_ARLOCK(mem_ARLOCK), .mem_ARCACHE(mem_ARCACHE),
    .mem_ARPROT(mem_ARPROT), .mem_ARQOS(mem_ARQOS),
    .mem_RVALID(mem_RVALID), .mem_RDATA(mem_RDATA), .mem_RID(mem_RID),
    .mem_RLAST(mem_RLAST), .mem_RRESP(mem_RRESP), .mem_RREADY(mem_RREADY),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .done(done), .err(err)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [39:0] exp_ar[$];
  logic [64:0] exp_out[$];
  logic [39:0] b_q[$];

  logic [31:0] cmd_tag = 32'h0;
  logic [31:0] r_addr;
  int          r_rem = 0;
  bit          r_busy = 0, r_acc = 0;
  int          r_allow = 1000000;
  int          r_loaded = 0;
  int          err_idx = -1;
  bit          out_toggle = 0;
  bit          rready_stall = 0;
  int          ar_cnt = 0, out_cnt = 0;
  int          cur_beats = 0;
  bit          prev_last = 0, first_cyc = 0;

  bit          arv_s, ar_fire, out_fire, done_s, err_s;
  logic [39:0] ar_s;
  logic [64:0] out_s;

  // one clock of slave + sampling; inputs are driven and outputs sampled at the falling edge
  task automatic step();
    logic [39:0] b;
    @(negedge clk);
    if (r_acc) begin
      r_addr = r_addr + 32'd8;
      r_rem--;
      r_loaded++;
      if (r_rem == 0) r_busy = 0;
    end
    if (!r_busy && b_q.size() > 0 && r_allow > 0) begin
      b = b_q.pop_front();
      r_addr = b[39:8];
      r_rem = int'(b[7:0]) + 1;
      r_busy = 1;
      r_allow--;
    end
    mem_RVALID  = r_busy;
    mem_RDATA   = {cmd_tag, r_addr};
    mem_RLAST   = r_busy && (r_rem == 1);
    mem_RRESP   = (r_busy && r_loaded == err_idx) ? 2'b10 : 2'b00;
    mem_RID     = 6'h15;
    mem_ARREADY = 1'b1;
    out_ready   = out_toggle ? !out_ready : 1'b1;
    arv_s   = mem_ARVALID;
    ar_fire = mem_ARVALID && mem_ARREADY;
    ar_s    = {mem_ARADDR, mem_ARLEN};
    if (ar_fire) begin
      b_q.push_back(ar_s);
      ar_cnt++;
    end
    r_acc = mem_RVALID && mem_RREADY;
    if (mem_RVALID && !mem_RREADY) rready_stall = 1;
    out_fire = out_valid && out_ready;
    out_s    = {out_last, out_data};
    if (out_fire) out_cnt++;
    done_s = done;
    err_s  = err;
  endtask

  task automatic start_cmd(input logic [31:0] a, input logic [31:0] nbytes);
    int     guard = 0;
    longint ca, rem, bnd, l;
    while (!cmd_ready && guard < 200) begin
      step();
      guard++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
    end
    cmd_tag   = cmd_tag + 32'h1;
    r_loaded  = 0;
    ar_cnt    = 0;
    out_cnt   = 0;
    cur_beats = int'((longint'(nbytes) + 7) / 8);
    prev_last = (cur_beats == 0);
    first_cyc = 1;
    ca  = longint'({a[31:3], 3'b000});
    rem = cur_beats;
    for (int k = 0; k < cur_beats; k++)
      exp_out.push_back({(k == cur_beats - 1), cmd_tag, 32'(ca + 8 * k)});
    while (rem > 0) begin
      bnd = (4096 - (ca % 4096)) / 8;
      l = 16;
      if (rem < l) l = rem;
      if (bnd < l) l = bnd;
      exp_ar.push_back({ca[31:0], 8'(l - 1)});
      ca  += l * 8;
      rem -= l;
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_bytes = nbytes;
  endtask

  task automatic drain_cmd(input bit expect_done, input bit exp_err, input int cycles,
                           input string name);
    bit          got_done = 0;
    logic [64:0] w;
    logic [39:0] wa;
    for (int c = 0; c < cycles; c++) begin
      step();
      cmd_valid = 1'b0;
      if (first_cyc) begin
        first_cyc = 0;
        vectors++;
        if (arv_s !== (cur_beats != 0)) begin
          miscompares++;
          $display("FAIL %s arvalid_latency: got %b want %b", name, arv_s, (cur_beats != 0));
        end
      end
      if (ar_fire) begin
        vectors++;
        if (exp_ar.size() == 0) begin
          miscompares++;
          $display("FAIL %s extra_ar: got %h want none", name, ar_s);
        end else begin
          wa = exp_ar.pop_front();
          if (ar_s !== wa) begin
            miscompares++;
            $display("FAIL %s ar_addr_len: got %h want %h", name, ar_s, wa);
          end
        end
      end
      if (out_fire) begin
        vectors++;
        if (exp_out.size() == 0) begin
          miscompares++;
          $display("FAIL %s extra_beat: got %h want none", name, out_s);
        end else begin
          w = exp_out.pop_front();
          if (out_s !== w) begin
            miscompares++;
            $display("FAIL %s out_beat: got %h want %h", name, out_s, w);
          end
        end
      end
      if (prev_last || done_s) begin
        vectors++;
        if (done_s !== prev_last) begin
          miscompares++;
          $display("FAIL %s done_timing: got %b want %b", name, done_s, prev_last);
        end
      end
      prev_last = out_fire && out_s[64];
      if (done_s) begin
        got_done = 1;
        vectors++;
        if (err_s !== exp_err || exp_out.size() != 0 || exp_ar.size() != 0) begin
          miscompares++;
          $display("FAIL %s done_state: err got %b want %b, beats left %0d want 0, ars left %0d want 0",
                   name, err_s, exp_err, exp_out.size(), exp_ar.size());
        end
        break;
      end
    end
    if (expect_done) begin
      vectors++;
      if (!got_done) begin
        miscompares++;
        $display("FAIL %s timeout: got no done want done within %0d cycles", name, cycles);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_bytes = '0;
    mem_ARREADY = 1'b0; mem_RVALID = 1'b0; mem_RDATA = '0; mem_RID = '0;
    mem_RLAST = 1'b0; mem_RRESP = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({mem_ARVALID, mem_RREADY, out_valid, out_last, done, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 000000",
               {mem_ARVALID, mem_RREADY, out_valid, out_last, done, err});
    end
    vectors++;
    if ({mem_ARSIZE, mem_ARBURST, mem_ARID, mem_ARLOCK, mem_ARCACHE, mem_ARPROT, mem_ARQOS}
        !== {3'd3, 2'b01, 6'd0, 1'b0, 4'b0011, 3'b000, 4'b0000}) begin
      miscompares++;
      $display("FAIL ar_constants: got %h want %h",
               {mem_ARSIZE, mem_ARBURST, mem_ARID, mem_ARLOCK, mem_ARCACHE, mem_ARPROT, mem_ARQOS},
               {3'd3, 2'b01, 6'd0, 1'b0, 4'b0011, 3'b000, 4'b0000});
    end
    reset = 1'b1;
    step();
    vectors++;
    if ({cmd_ready, mem_RREADY} !== 2'b11) begin
      miscompares++;
      $display("FAIL post_reset_ready: got %b want 11", {cmd_ready, mem_RREADY});
    end
  endtask

  task automatic test_single();
    start_cmd(32'h1000, 32'd128);
    drain_cmd(1, 0, 200, "single");
    vectors++;
    if (ar_cnt != 1 || out_cnt != 16) begin
      miscompares++;
      $display("FAIL single_counts: got ars %0d beats %0d want ars 1 beats 16", ar_cnt, out_cnt);
    end
    step();
    vectors++;
    if (done_s !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done_pulse: got %b want 0", done_s);
    end
  endtask

  task automatic test_boundary();
    start_cmd(32'h0000_0FF0, 32'd64);
    drain_cmd(1, 0, 200, "page_cross");
    vectors++;
    if (ar_cnt != 2 || out_cnt != 8) begin
      miscompares++;
      $display("FAIL page_cross_counts: got ars %0d beats %0d want ars 2 beats 8", ar_cnt, out_cnt);
    end
    start_cmd(32'h0000_5007, 32'd13);
    drain_cmd(1, 0, 200, "unaligned");
  endtask

  task automatic test_outstanding();
    r_allow = 0;
    start_cmd(32'h0, 32'd1000);
    drain_cmd(0, 0, 20, "outst_hold");
    vectors++;
    if (ar_cnt != 4 || arv_s !== 1'b0) begin
      miscompares++;
      $display("FAIL outst_limit: got ars %0d arvalid %b want ars 4 arvalid 0", ar_cnt, arv_s);
    end
    r_allow = 1;
    drain_cmd(0, 0, 40, "outst_one");
    vectors++;
    if (ar_cnt != 5) begin
      miscompares++;
      $display("FAIL outst_release: got ars %0d want 5", ar_cnt);
    end
    r_allow = 1000000;
    drain_cmd(1, 0, 1000, "outst_all");
    vectors++;
    if (out_cnt != 125 || ar_cnt != 8) begin
      miscompares++;
      $display("FAIL outst_total: got beats %0d ars %0d want beats 125 ars 8", out_cnt, ar_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_toggle = 1;
    rready_stall = 0;
    start_cmd(32'h2000, 32'd256);
    drain_cmd(1, 0, 400, "toggle_ready");
    out_toggle = 0;
    vectors++;
    if (rready_stall !== 1'b1 || out_cnt != 32) begin
      miscompares++;
      $display("FAIL toggle_flow: got rready_stall %b beats %0d want 1 and 32", rready_stall, out_cnt);
    end
  endtask

  task automatic test_resp_err();
    err_idx = 2;
    start_cmd(32'h3000, 32'd64);
    drain_cmd(1, 1, 200, "resp_err");
    vectors++;
    if (out_cnt != 8) begin
      miscompares++;
      $display("FAIL resp_err_beats: got %0d want 8", out_cnt);
    end
    err_idx = -1;
    start_cmd(32'h3100, 32'd64);
    drain_cmd(1, 0, 200, "resp_clean");
  endtask

  task automatic test_zero();
    start_cmd(32'h4000, 32'd0);
    drain_cmd(1, 0, 5, "zero_bytes");
    vectors++;
    if (ar_cnt != 0) begin
      miscompares++;
      $display("FAIL zero_no_ar: got %0d want 0", ar_cnt);
    end
  endtask

  task automatic test_back_to_back();
    start_cmd(32'h8000, 32'd40);
    drain_cmd(1, 0, 200, "b2b_first");
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready_after_done: got %b want 1", cmd_ready);
    end
    start_cmd(32'h8100, 32'd40);
    drain_cmd(1, 0, 200, "b2b_second");
  endtask

  task automatic test_reset_drain();
    out_toggle = 1;
    start_cmd(32'h0, 32'd512);
    drain_cmd(0, 0, 30, "rst_drain_run");
    vectors++;
    if (ar_cnt != 4 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_drain_setup: got ars %0d out_valid %b want 4 and 1", ar_cnt, out_valid);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({mem_ARVALID, mem_RREADY, out_valid, out_last, done, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_drain_async: got %b want 000000",
               {mem_ARVALID, mem_RREADY, out_valid, out_last, done, err});
    end
    b_q.delete(); exp_out.delete(); exp_ar.delete();
    r_busy = 0; r_acc = 0; out_toggle = 0;
    mem_RVALID = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    start_cmd(32'h40, 32'd24);
    drain_cmd(1, 0, 200, "post_reset_cmd");
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_outstanding();
    test_backpressure();
    test_resp_err();
    test_zero();
    test_back_to_back();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_rd_burst_gen.md
# axi_rd_burst_gen

Read-side DMA front end for one accelerator memory port (`memN_*`): accepts a (base address, byte count) command, splits it into AXI4 INCR read bursts of 64-bit beats, and streams the returned data to the accelerator with a last-beat marker. It sits directly upstream of a board-wrapper memory master port; one instance per `memN` read channel. The `memN_AW*`, `memN_W*` and `memN_B*` channels are outside this block.

## Interface
- `MAX_BURST`, 16: maximum beats per burst; power of two, 1..256.
- `MAX_OUTST`, 4: maximum bursts in flight; ≥1.
- `ID`, 0: constant ARID value, 6 bits.

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: command accept.
- `cmd_addr` input 32: byte address; bits [2:0] ignored.
- `cmd_bytes` input 32: byte count; rounded up to a multiple of 8.
- `mem_ARVALID` output 1.
- `mem_ARREADY` input 1.
- `mem_ARADDR` output 32.
- `mem_ARLEN` output 8.
- `mem_ARSIZE` output 3: constant 3.
- `mem_ARBURST` output 2: constant 01.
- `mem_ARID` output 6: constant `ID`.
- `mem_ARLOCK` output 1: constant 0.
- `mem_ARCACHE` output 4: constant 0011.
- `mem_ARPROT` output 3: constant 000.
- `mem_ARQOS` output 4: constant 0000.
- `mem_RVALID`, `mem_RDATA[63:0]`, `mem_RID[5:0]`, `mem_RLAST`, `mem_RRESP[1:0]` inputs.
- `mem_RREADY` output 1.
- `out_valid`, `out_data[63:0]`, `out_last` outputs.
- `out_ready` input 1.
- `done` output 1: one-cycle pulse when a command has completed.
- `err` output 1: valid only together with `done`; high if any beat of the command had RRESP≠00.

## Operation
- The FSM has three states: IDLE, ISSUE and DRAIN.
  - `cmd_ready` is high only in IDLE.
- Command accept:
  - A handshake latches `addr = {cmd_addr[31:3],3'b000}` and `beats = ceil(cmd_bytes/8)` into a 29-bit register.
  - It also clears the error flag and the received-beat counter.
  - If `beats==0`, the block pulses `done` (err=0) on the next cycle and stays in IDLE.
  - Otherwise it goes to ISSUE.
- ISSUE:
  - Burst length is `len = min(MAX_BURST, beats_left, (4096 - addr[11:0])/8)`, so a burst never crosses a 4 KB boundary.
  - `ARLEN = len-1`.
  - `mem_ARVALID` is asserted only while `outstanding < MAX_OUTST`.
  - Once asserted, `ARVALID`, `ARADDR` and `ARLEN` stay stable until `ARREADY`.
  - On an AR handshake: `addr += len*8`, `beats_left -= len`, `outstanding++`.
  - When `beats_left` reaches 0, the FSM goes to DRAIN.
- R channel:
  - The R channel feeds the `axi_skid_buf` input, and `mem_RREADY` = the buffer's input ready.
  - On each accepted R beat: `rcv++`. A beat with `mem_RLAST` also does `outstanding--`. A beat with RRESP≠00 sets the sticky error flag.
  - `RID` is ignored.
- `out_last` is set on the beat where `rcv == beats-1`; it is carried through the buffer with the data.
- DRAIN: when a beat with `out_last` completes on the output side (`out_valid && out_ready`):
  - `done` pulses on the next cycle with `err` = the sticky flag;
  - the FSM returns to IDLE.
- Simultaneous AR handshake and RLAST in the same cycle leave `outstanding` unchanged.
- Reset mid-command:
  - drops all state immediately;
  - in-flight AXI transactions are abandoned, and the system resets the interconnect together with this block.

## Timing
- Reset values:
  - `mem_ARVALID=0`, `mem_RREADY=0`, `out_valid=0`, `out_last=0`, `done=0`, `err=0`.
  - `cmd_ready=1` after the first edge with reset deasserted.
  - Counters and address are 0.
- First `ARVALID` appears 1 cycle after command accept.
- Back-to-back AR issues: one per cycle while `ARREADY` is high and the outstanding limit allows it.
- Data latency from R to out is 1 cycle.
  - With `out_ready` held high, throughput is 1 beat/cycle.
  - `out_valid` and `out_data` are stable while `out_ready` is low.
- A new command can be accepted the cycle after `done`.

## Structure
- Shared package `axi_pkg`:
  - `AXI_BURST_INCR=2'b01`, `AXI_SIZE_8B=3'd3`, `AXI_CACHE_DEF=4'b0011`, `AXI_RESP_OKAY=2'b00`;
  - the FSM state enum typedef.
- Sub-module `axi_skid_buf` (parameter `W`): 2-entry registered valid/ready buffer, used here with W=65 (data + last).

## Test plan
- `addr=0x1000, bytes=128`, AR/R/out always ready → one AR with ARADDR=0x1000, ARLEN=15. 16 beats out, `out_last` on beat 16. `done` 1 cycle after, err=0.
- `addr=0x0FF0, bytes=64` → ARs (0x0FF0, len 1) then (0x1000, len 5). 8 beats out, single `out_last`.
- `bytes=1000`, MAX_OUTST=4, slave withholds R data → exactly 4 ARs issued and `ARVALID` then stays low. Releasing one RLAST allows the 5th AR. Total 125 beats.
- `out_ready` toggled 1/0 every cycle → no beat lost or duplicated. `mem_RREADY` deasserts when the buffer is full. Data order matches an incrementing pattern.
- Beat 3 of 8 returns RRESP=10 → all 8 beats delivered, `done` with err=1. The next command with clean responses gives err=0.
- `bytes=0` → `done` pulse 1 cycle after accept, no ARVALID. Separately, reset asserted during DRAIN → all outputs return to reset values asynchronously.
